register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file_pkg.sv | 11 +
 rtl/register_file_read_port.sv | 55 +++++
 rtl/register_file.sv | 74 +++++++
 tb/tb_register_file.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared processor constants used by the register file.
//   REG_WIDTH : architectural register width of the processor
//   RF_WIDTH  : default data width of each register-file entry
//   RF_NREGS  : default number of register-file entries (power of two)
//   RF_NPORTS : number of independent read ports
package register_file_pkg;
    localparam int REG_WIDTH = 32;
    localparam int RF_WIDTH  = REG_WIDTH;
    localparam int RF_NREGS  = 32;
    localparam int RF_NPORTS = 2;
endpackage

// File: rtl/register_file_read_port.sv
// One read port of the register file: address mux, write-forwarding
// compare and the registered data/valid outputs.
//   clk, rst_n_i        : clock, async active-low reset
//   regs_i              : flattened view of all registers
//   we_i, wa_i, din_i   : write port, observed for forwarding
//   re_i, ra_i          : read request / address
//   dout_o, vld_o       : registered read data and valid
module read_port
    import register_file_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int NREGS = RF_NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                        clk,
    input  logic                        rst_n_i,
    input  logic [NREGS-1:0][WIDTH-1:0] regs_i,
    input  logic                        we_i,
    input  logic [AW-1:0]               wa_i,
    input  logic [WIDTH-1:0]            din_i,
    input  logic                        re_i,
    input  logic [AW-1:0]               ra_i,
    output logic [WIDTH-1:0]            dout_o,
    output logic                        vld_o
);
    logic             fwd;
    logic [WIDTH-1:0] dout_d, dout_q;
    logic             vld_q;

    // A same-edge write to the read address wins over stored contents.
    // Address 0 never forwards and always reads as zero.
    always_comb begin
        fwd    = we_i && (ra_i == wa_i) && (wa_i != '0);
        dout_d = regs_i[ra_i];
        if (ra_i == '0)
            dout_d = '0;
        else if (fwd)
            dout_d = din_i;
    end

    // Data holds when no read is requested; valid tracks the request.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dout_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= re_i;
            if (re_i)
                dout_q <= dout_d;
        end
    end

    assign dout_o = dout_q;
    assign vld_o  = vld_q;
endmodule

// File: rtl/register_file.sv
// Flop-based register file, one write port and two registered read ports
// with one-cycle latency and write-to-read forwarding. Register 0 reads
// as zero and ignores writes.
//   clk          : clock (rising edge)
//   rst          : async active-low reset, clears registers and outputs
//   we, wa, din  : write enable / address / data
//   re1, ra1     : read port 1 request / address
//   re2, ra2     : read port 2 request / address
//   dout1, vld1  : read port 1 data / valid
//   dout2, vld2  : read port 2 data / valid
module register_file
    import register_file_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int NREGS = RF_NREGS,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] din,
    input  logic             re1,
    input  logic [AW-1:0]    ra1,
    input  logic             re2,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic             vld1,
    output logic             vld2
);
    logic [NREGS-1:0][WIDTH-1:0] regs_q;

    // Entry 0 is never written, so it stays at its reset value of zero
    // and synthesis reduces it to constants.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            regs_q <= '0;
        else if (we && (wa != '0))
            regs_q[wa] <= din;
    end

    logic [RF_NPORTS-1:0]            re_v;
    logic [RF_NPORTS-1:0][AW-1:0]    ra_v;
    logic [RF_NPORTS-1:0][WIDTH-1:0] dout_v;
    logic [RF_NPORTS-1:0]            vld_v;

    assign re_v = {re2, re1};
    assign ra_v = {ra2, ra1};

    for (genvar p = 0; p < RF_NPORTS; p++) begin : g_rd
        read_port #(
            .WIDTH (WIDTH),
            .NREGS (NREGS),
            .AW    (AW)
        ) u_rd (
            .clk     (clk),
            .rst_n_i (rst),
            .regs_i  (regs_q),
            .we_i    (we),
            .wa_i    (wa),
            .din_i   (din),
            .re_i    (re_v[p]),
            .ra_i    (ra_v[p]),
            .dout_o  (dout_v[p]),
            .vld_o   (vld_v[p])
        );
    end

    assign dout1 = dout_v[0];
    assign dout2 = dout_v[1];
    assign vld1  = vld_v[0];
    assign vld2  = vld_v[1];
endmodule

// File: tb/tb_register_file.sv
module tb_register_file;
    localparam int WIDTH = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             we;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] din;
    logic             re1, re2;
    logic [AW-1:0]    ra1, ra2;
    logic [WIDTH-1:0] dout1, dout2;
    logic             vld1, vld2;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] q1[$];
    logic [WIDTH-1:0] q2[$];
    logic [WIDTH-1:0] mem[NREGS];

    register_file #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .din(din),
        .re1(re1), .ra1(ra1), .re2(re2), .ra2(ra2),
        .dout1(dout1), .dout2(dout2), .vld1(vld1), .vld2(vld2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: whenever a port presents valid data, pop and compare.
    always @(negedge clk) begin
        if (vld1 === 1'b1) begin
            if (q1.size() == 0) chk("port1 unexpected vld", 1, 0);
            else chk("port1 data", dout1, q1.pop_front());
        end
        if (vld2 === 1'b1) begin
            if (q2.size() == 0) chk("port2 unexpected vld", 1, 0);
            else chk("port2 data", dout2, q2.pop_front());
        end
    end

    // Apply one cycle of stimulus just after a rising edge; it is captured
    // on the next edge. Expected read data is queued at issue time.
    task automatic drive(input logic w, input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                         input logic r1, input logic [AW-1:0] a1, input logic [WIDTH-1:0] e1,
                         input logic r2, input logic [AW-1:0] a2, input logic [WIDTH-1:0] e2);
        @(posedge clk);
        #1;
        we = w; wa = a; din = d;
        re1 = r1; ra1 = a1; re2 = r2; ra2 = a2;
        if (r1) q1.push_back(e1);
        if (r2) q2.push_back(e2);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; we = 0; wa = 0; din = 0; re1 = 0; ra1 = 0; re2 = 0; ra2 = 0;
        #2;
        chk("reset dout1", dout1, 0);
        chk("reset vld1", {31'b0, vld1}, 0);
        chk("reset dout2", dout2, 0);
        chk("reset vld2", {31'b0, vld2}, 0);
        #10 rst = 1'b1;

        // Basic write then read
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        // Register 0 discards writes
        drive(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
        // Forwarding on both ports, then confirm the write landed
        drive(1, 7, 32'h1, 0, 0, 0, 0, 0, 0);
        drive(1, 7, 32'hA5A5A5A5, 1, 7, 32'hA5A5A5A5, 1, 7, 32'hA5A5A5A5);
        drive(0, 0, 0, 1, 7, 32'hA5A5A5A5, 1, 7, 32'hA5A5A5A5);
        // Hold: dout keeps old value when no read is requested
        drive(1, 3, 32'h12345678, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 3, 32'h12345678, 0, 0, 0);
        drive(1, 3, 32'h0, 0, 0, 0, 0, 0, 0);
        idle();
        #1;
        chk("hold dout1", dout1, 32'h12345678);
        chk("hold vld1", {31'b0, vld1}, 0);
        drive(0, 0, 0, 1, 3, 32'h0, 1, 3, 32'h0);

        // Throughput: fill 1..31, then stream reads on both ports
        for (int i = 1; i < NREGS; i++) begin
            mem[i] = 32'h01010101 * i ^ 32'h5A000000;
            drive(1, AW'(i), mem[i], 0, 0, 0, 0, 0, 0);
        end
        for (int i = 1; i < NREGS; i++) begin
            drive(0, 0, 0, 1, AW'(i), mem[i], 1, AW'(NREGS - i), mem[NREGS - i]);
            if (i > 1) chk("stream vld", {30'b0, vld1, vld2}, 32'h3);
        end
        idle();

        // Mid-run reset while a read is in flight
        drive(0, 0, 0, 1, 5, mem[5], 0, 0, 0);
        drive(1, 9, 32'h0000FFFF, 1, 9, 0, 1, 2, 0);
        q1.pop_back(); q2.pop_back(); // suppressed by reset below
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midreset dout1", dout1, 0);
        chk("midreset vld1", {31'b0, vld1}, 0);
        chk("midreset dout2", dout2, 0);
        chk("midreset vld2", {31'b0, vld2}, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("inreset vld", {30'b0, vld1, vld2}, 0);
        we = 0; re1 = 0; re2 = 0;
        #1 rst = 1'b1;
        for (int a = 0; a < NREGS; a++)
            drive(0, 0, 0, 1, AW'(a), 0, 1, AW'(NREGS - 1 - a), 0);
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("port1 queue drained", q1.size(), 0);
        chk("port2 queue drained", q2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
